uart_apb_slave: RTL and testbench

APB slave wrapping a full-duplex 8N1 UART (transmitter plus receiver) behind a small register map. The CPU/bus side writes TX bytes and reads RX bytes and status over APB. The serial side drives `ser_out` and samples `ser_in`. Two instances may be cross-wired for loopback, one acting as transmitter and one as receiver, each gated by its own enable.

---
 rtl/uart_apb_slave.sv | 243 ++++++++++++++++++++++++
 tb/tb_uart_apb_slave.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_apb_slave.sv
// APB slave fronting a full-duplex 8N1 UART: TX holding register, RX data register and status flags.
// Serial TX/RX engines run from pclk with a per-bit cycle counter.
module uart_apb_slave #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] pstrb,
  input  logic [31:0] padd,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslevrr,
  output logic        apb_done,
  input  logic        ser_in,
  output logic        ser_out,
  input  logic        tx_enable,
  input  logic        rx_enable
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BIT_HALF = CW'(CLKS_PER_BIT / 2);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  state_e        tx_state_q, tx_state_d, rx_state_q, rx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
  logic [7:0]    tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d;
  logic [7:0]    tx_hold_q, tx_hold_d, rx_byte_q, rx_byte_d;
  logic          tx_pending_q, tx_pending_d, ser_out_q, ser_out_d;
  logic          rx_valid_q, rx_valid_d, rx_overrun_q, rx_overrun_d;
  logic          rx_frame_err_q, rx_frame_err_d;
  logic          sync1_q, sync1_d, sync2_q, sync2_d;

  logic access, sel_rx, sel_tx, sel_st, acc_err, wr_ok, rd_ok;
  logic tx_start, rx_got, rx_bad, rx_read, tx_busy;
  logic unused_bits;

  assign unused_bits = ^{pstrb, pwdata[31:8]};

  assign access   = psel & penable;
  assign sel_rx   = (padd == 32'h0000_0078);
  assign sel_tx   = (padd == 32'h0000_0079);
  assign sel_st   = (padd == 32'h0000_007A);
  assign acc_err  = access & (~(sel_rx | sel_tx | sel_st) | (pwrite & sel_rx));
  assign wr_ok    = access & pwrite & ~acc_err;
  assign rd_ok    = access & ~pwrite & ~acc_err;
  assign rx_read  = rd_ok & sel_rx;
  assign tx_busy  = (tx_state_q != S_IDLE);
  assign tx_start = (tx_state_q == S_IDLE) & tx_pending_q & tx_enable;

  assign pready   = access;
  assign apb_done = access & pready;
  assign pslevrr  = acc_err;
  assign ser_out  = ser_out_q;

  always_comb begin
    prdata = 32'h0;
    if (rd_ok) begin
      if (sel_rx)      prdata = {23'b0, rx_valid_q, rx_byte_q};
      else if (sel_tx) prdata = {23'b0, tx_pending_q, tx_hold_q};
      else             prdata = {27'b0, rx_frame_err_q, rx_overrun_q, rx_valid_q, tx_busy, tx_pending_q};
    end
  end

  // TX engine; ser_out is registered from the current state so it lags the state by one cycle
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    case (tx_state_q)
      S_IDLE: begin
        if (tx_start) begin
          tx_state_d = S_START;
          tx_cnt_d   = '0;
          tx_shift_d = tx_hold_q;
        end
      end
      S_START: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_state_d = S_DATA;
          tx_cnt_d   = '0;
          tx_bit_d   = 3'd0;
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          if (tx_bit_q == 3'd7) tx_state_d = S_STOP;
          else                  tx_bit_d   = tx_bit_q + 3'd1;
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_state_d = S_IDLE;
          tx_cnt_d   = '0;
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      default: tx_state_d = S_IDLE;
    endcase

    case (tx_state_q)
      S_START: ser_out_d = 1'b0;
      S_DATA:  ser_out_d = tx_shift_q[0];
      default: ser_out_d = 1'b1;
    endcase
  end

  always_comb begin
    sync1_d    = ser_in;
    sync2_d    = sync1_q;
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_got     = 1'b0;
    rx_bad     = 1'b0;
    case (rx_state_q)
      S_IDLE: begin
        if (!sync2_q) begin
          rx_state_d = S_START;
          rx_cnt_d   = '0;
        end
      end
      S_START: begin
        if (rx_cnt_q == BIT_HALF) begin
          rx_cnt_d   = '0;
          rx_bit_d   = 3'd0;
          rx_state_d = sync2_q ? S_IDLE : S_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {sync2_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_state_d = S_IDLE;
          rx_cnt_d   = '0;
          rx_got     = sync2_q;
          rx_bad     = ~sync2_q;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      default: rx_state_d = S_IDLE;
    endcase
    if (!rx_enable) begin
      rx_state_d = S_IDLE;
      rx_cnt_d   = '0;
      rx_got     = 1'b0;
      rx_bad     = 1'b0;
    end
  end

  // Register file: hardware set events take priority over bus clears on the same cycle
  always_comb begin
    tx_hold_d      = tx_hold_q;
    tx_pending_d   = tx_pending_q;
    rx_byte_d      = rx_byte_q;
    rx_valid_d     = rx_valid_q;
    rx_overrun_d   = rx_overrun_q;
    rx_frame_err_d = rx_frame_err_q;

    if (tx_start) tx_pending_d = 1'b0;
    if (wr_ok && sel_tx) begin
      tx_hold_d    = pwdata[7:0];
      tx_pending_d = 1'b1;
    end

    if (rx_read) rx_valid_d = 1'b0;
    if (wr_ok && sel_st && pwdata[3]) rx_overrun_d   = 1'b0;
    if (wr_ok && sel_st && pwdata[4]) rx_frame_err_d = 1'b0;
    if (rx_got) begin
      rx_byte_d  = rx_shift_q;
      rx_valid_d = 1'b1;
      if (rx_valid_q && !rx_read) rx_overrun_d = 1'b1;
    end
    if (rx_bad) rx_frame_err_d = 1'b1;
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      tx_state_q     <= S_IDLE;
      rx_state_q     <= S_IDLE;
      tx_cnt_q       <= '0;
      rx_cnt_q       <= '0;
      tx_bit_q       <= 3'd0;
      rx_bit_q       <= 3'd0;
      tx_shift_q     <= 8'h0;
      rx_shift_q     <= 8'h0;
      tx_hold_q      <= 8'h0;
      rx_byte_q      <= 8'h0;
      tx_pending_q   <= 1'b0;
      ser_out_q      <= 1'b1;
      rx_valid_q     <= 1'b0;
      rx_overrun_q   <= 1'b0;
      rx_frame_err_q <= 1'b0;
      sync1_q        <= 1'b1;
      sync2_q        <= 1'b1;
    end else begin
      tx_state_q     <= tx_state_d;
      rx_state_q     <= rx_state_d;
      tx_cnt_q       <= tx_cnt_d;
      rx_cnt_q       <= rx_cnt_d;
      tx_bit_q       <= tx_bit_d;
      rx_bit_q       <= rx_bit_d;
      tx_shift_q     <= tx_shift_d;
      rx_shift_q     <= rx_shift_d;
      tx_hold_q      <= tx_hold_d;
      rx_byte_q      <= rx_byte_d;
      tx_pending_q   <= tx_pending_d;
      ser_out_q      <= ser_out_d;
      rx_valid_q     <= rx_valid_d;
      rx_overrun_q   <= rx_overrun_d;
      rx_frame_err_q <= rx_frame_err_d;
      sync1_q        <= sync1_d;
      sync2_q        <= sync2_d;
    end
  end

endmodule

// File: tb/tb_uart_apb_slave.sv
// Self-checking bench: instance A transmits into instance B; the bench can also drive B's line directly.
module tb_uart_apb_slave;
  localparam int C = 87;

  logic        pclk = 1'b0;
  logic        rst = 1'b1;
  logic        psel_a = 1'b0, psel_b = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0] pstrb = 32'h0, padd = 32'h0, pwdata = 32'h0;
  logic [31:0] prdata_a, prdata_b;
  logic        pready_a, pready_b, pslverr_a, pslverr_b, done_a, done_b;
  logic        ser_out_a, ser_out_b, ser_in_b;
  logic        tx_enable_a = 1'b0, tx_enable_b = 1'b0, rx_enable_a = 1'b0, rx_enable_b = 1'b1;
  logic        sel_drv = 1'b0, tb_ser = 1'b1;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];
  logic [7:0]  ser_q[$];

  assign ser_in_b = sel_drv ? tb_ser : ser_out_a;

  always #5 pclk = ~pclk;

  uart_apb_slave #(.CLKS_PER_BIT(C)) u_a (
    .pclk(pclk), .rst(rst), .psel(psel_a), .penable(penable), .pwrite(pwrite),
    .pstrb(pstrb), .padd(padd), .pwdata(pwdata), .prdata(prdata_a), .pready(pready_a),
    .pslevrr(pslverr_a), .apb_done(done_a), .ser_in(ser_out_b), .ser_out(ser_out_a),
    .tx_enable(tx_enable_a), .rx_enable(rx_enable_a)
  );

  uart_apb_slave #(.CLKS_PER_BIT(C)) u_b (
    .pclk(pclk), .rst(rst), .psel(psel_b), .penable(penable), .pwrite(pwrite),
    .pstrb(pstrb), .padd(padd), .pwdata(pwdata), .prdata(prdata_b), .pready(pready_b),
    .pslevrr(pslverr_b), .apb_done(done_b), .ser_in(ser_in_b), .ser_out(ser_out_b),
    .tx_enable(tx_enable_b), .rx_enable(rx_enable_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic apb(input bit inst, input bit wr, input logic [31:0] addr, input logic [31:0] data,
                     output logic [31:0] rd, output logic err, output logic rdy, output logic done);
    @(posedge pclk); #1;
    psel_a = ~inst; psel_b = inst; pwrite = wr; padd = addr; pwdata = data; penable = 1'b0;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(negedge pclk);
    rd   = inst ? prdata_b  : prdata_a;
    err  = inst ? pslverr_b : pslverr_a;
    rdy  = inst ? pready_b  : pready_a;
    done = inst ? done_b    : done_a;
    @(posedge pclk); #1;
    psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic rd_chk(input bit inst, input logic [31:0] addr, input logic [31:0] exp, input string tag);
    logic [31:0] rd;
    logic e, r, d;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    apb(inst, 1'b0, addr, 32'h0, rd, e, r, d);
    check(tag_q.pop_front(), rd, exp_q.pop_front());
  endtask

  task automatic wr_reg(input bit inst, input logic [31:0] addr, input logic [31:0] data,
                        input logic exp_err, input string tag);
    logic [31:0] rd;
    logic e, r, d;
    apb(inst, 1'b1, addr, data, rd, e, r, d);
    check({tag, "_err"}, 32'(e), 32'(exp_err));
  endtask

  task automatic wait_bit(input bit inst, input int bitn, input logic val, input int maxp, input string tag);
    logic [31:0] rd;
    logic e, r, d;
    bit hit = 1'b0;
    for (int k = 0; k < maxp && !hit; k++) begin
      apb(inst, 1'b0, 32'h7A, 32'h0, rd, e, r, d);
      if (rd[bitn] === val) hit = 1'b1;
    end
    if (!hit) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  // Samples A's serial line at bit centres and compares each frame against the queued byte
  task automatic ser_check(input int n);
    logic [7:0] got;
    for (int f = 0; f < n; f++) begin
      for (int k = 0; k < 3000 && ser_out_a !== 1'b0; k++) @(negedge pclk);
      if (ser_out_a !== 1'b0) begin
        check("ser_start_timeout", 32'(ser_out_a), 32'd0);
        return;
      end
      repeat (C / 2) @(negedge pclk);
      check("ser_startbit", 32'(ser_out_a), 32'd0);
      for (int i = 0; i < 8; i++) begin
        repeat (C) @(negedge pclk);
        got[i] = ser_out_a;
      end
      repeat (C) @(negedge pclk);
      check("ser_stopbit", 32'(ser_out_a), 32'd1);
      check("ser_byte", 32'(got), 32'(ser_q.pop_front()));
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok);
    @(posedge pclk); #1;
    tb_ser = 1'b0;
    repeat (C) @(posedge pclk);
    #1;
    for (int i = 0; i < 8; i++) begin
      tb_ser = b[i];
      repeat (C) @(posedge pclk);
      #1;
    end
    tb_ser = stop_ok;
    repeat (stop_ok ? C : (3 * C / 4)) @(posedge pclk);
    #1;
    tb_ser = 1'b1;
    repeat (2 * C) @(posedge pclk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic e, r, d;

    repeat (3) @(negedge pclk);
    check("rst_ser_out", 32'(ser_out_a), 32'd1);
    check("rst_prdata", prdata_a, 32'h0);
    check("rst_pready", 32'(pready_a), 32'd0);
    check("rst_pslverr", 32'(pslverr_a), 32'd0);
    check("rst_apb_done", 32'(done_a), 32'd0);
    rst = 1'b0;
    rd_chk(1'b0, 32'h7A, 32'h0, "rst_status_a");
    rd_chk(1'b1, 32'h7A, 32'h0, "rst_status_b");

    // Write TX byte with pstrb=0; upper pwdata bits ignored
    apb(1'b0, 1'b1, 32'h79, 32'h0000_2AAA, rd, e, r, d);
    check("wr79_pready", 32'(r), 32'd1);
    check("wr79_apb_done", 32'(d), 32'd1);
    check("wr79_pslverr", 32'(e), 32'd0);
    rd_chk(1'b0, 32'h79, 32'h1AA, "rd79_pending");

    ser_q.push_back(8'hAA);
    tx_enable_a = 1'b1;
    fork
      ser_check(1);
      wait_bit(1'b1, 2, 1'b1, 1000, "loop_rx_valid");
    join
    rd_chk(1'b1, 32'h78, 32'h1AA, "rx78_first");
    rd_chk(1'b1, 32'h78, 32'h0AA, "rx78_second");
    tx_enable_a = 1'b0;

    apb(1'b0, 1'b0, 32'h7C, 32'h0, rd, e, r, d);
    check("unmapped_pslverr", 32'(e), 32'd1);
    check("unmapped_prdata", rd, 32'h0);
    wr_reg(1'b0, 32'h78, 32'hFF, 1'b1, "wr78");
    rd_chk(1'b0, 32'h79, 32'h0AA, "rd79_after_err");
    rd_chk(1'b0, 32'h78, 32'h000, "rd78_after_err");

    // Two bytes back to back without reading RX_DATA -> overrun
    wr_reg(1'b0, 32'h79, 32'h55, 1'b0, "wr79_55");
    ser_q.push_back(8'h55);
    ser_q.push_back(8'h33);
    tx_enable_a = 1'b1;
    fork
      ser_check(2);
      begin
        wait_bit(1'b0, 0, 1'b0, 200, "tx_pending_clear");
        wr_reg(1'b0, 32'h79, 32'h33, 1'b0, "wr79_33");
        wait_bit(1'b1, 3, 1'b1, 1000, "overrun_set");
      end
    join
    tx_enable_a = 1'b0;
    rd_chk(1'b1, 32'h7A, 32'h0C, "status_overrun");
    rd_chk(1'b1, 32'h78, 32'h133, "rx78_overrun_byte");
    wr_reg(1'b1, 32'h7A, 32'h08, 1'b0, "clr_overrun");
    rd_chk(1'b1, 32'h7A, 32'h00, "status_cleared");

    sel_drv = 1'b1;
    send_frame(8'h5A, 1'b0);
    rd_chk(1'b1, 32'h7A, 32'h10, "status_frame_err");
    wr_reg(1'b1, 32'h7A, 32'h10, 1'b0, "clr_frame_err");
    rd_chk(1'b1, 32'h7A, 32'h00, "status_fe_cleared");

    send_frame(8'hC3, 1'b1);
    rd_chk(1'b1, 32'h7A, 32'h04, "status_drv_valid");
    rd_chk(1'b1, 32'h78, 32'h1C3, "rx78_drv_byte");

    @(posedge pclk); #1;
    tb_ser = 1'b0;
    repeat (10) @(posedge pclk);
    #1;
    tb_ser = 1'b1;
    repeat (2 * C) @(posedge pclk);
    rd_chk(1'b1, 32'h7A, 32'h00, "status_glitch");

    rx_enable_b = 1'b0;
    send_frame(8'h77, 1'b1);
    rd_chk(1'b1, 32'h7A, 32'h00, "status_rx_disabled");
    rx_enable_b = 1'b1;
    sel_drv = 1'b0;

    // Reset in the middle of a TX start bit
    wr_reg(1'b0, 32'h79, 32'h0F, 1'b0, "wr79_0f");
    tx_enable_a = 1'b1;
    for (int k = 0; k < 50 && ser_out_a !== 1'b0; k++) @(negedge pclk);
    repeat (30) @(negedge pclk);
    check("pre_rst_ser_out", 32'(ser_out_a), 32'd0);
    #2 rst = 1'b1;
    #1 check("async_rst_ser_out", 32'(ser_out_a), 32'd1);
    tx_enable_a = 1'b0;
    repeat (3) @(negedge pclk);
    rst = 1'b0;
    rd_chk(1'b0, 32'h78, 32'h0, "post_rst_78");
    rd_chk(1'b0, 32'h79, 32'h0, "post_rst_79");
    rd_chk(1'b0, 32'h7A, 32'h0, "post_rst_status");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
